// File: rtl/store_stream_if.sv
// Store-bus and expected-RAM load signals watched by store_stream_checker.
// The master drives the bus; the checker observes it through the slave modport.
interface store_stream_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              exp_we;
    logic [IDX_W-1:0]  exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [IDX_W:0]    check_num;

    modport master (
        output addr, data, wen,
        output exp_we, exp_addr, exp_data, check_num
    );

    modport slave (
        input addr, data, wen,
        input exp_we, exp_addr, exp_data, check_num
    );
endinterface

// File: rtl/store_stream_checker.sv
// Self-checking store monitor: a BEGIN_SYM store to TEST_PORT starts a run, later TEST_PORT
// stores are compared against a loadable expected RAM, then errors/duration/timeout are reported.
module store_stream_checker #(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                IDX_W     = 8,
    parameter logic [ADDR_W-1:0] TEST_PORT = 30'hFF,
    parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h00000932,
    parameter int                ERR_W     = 8,
    parameter int                DUR_W     = 16,
    parameter int unsigned       TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    store_stream_if.slave     bus,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic              busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [IDX_W:0]   DEPTH_LAT = (IDX_W + 1)'(DEPTH);
    localparam logic [DUR_W-1:0] DUR_LAST  = DUR_W'(TIMEOUT - 1);

    logic [1:0]        state;
    logic              armed;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W:0]    num_lat;
    logic [DATA_W-1:0] exp_ram [DEPTH];

    logic              accepted;
    logic              begin_hit;
    logic [DATA_W-1:0] exp_word;
    logic              zero_run;
    logic              mismatch;
    logic [IDX_W:0]    idx_inc;
    logic              done_store;
    logic              at_limit;
    logic [ERR_W-1:0]  err_next;

    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        accepted   = bus.wen && armed && (bus.addr == TEST_PORT);
        begin_hit  = accepted && (bus.data == BEGIN_SYM);
        exp_word   = exp_ram[idx];
        zero_run   = (num_lat == '0);
        mismatch   = accepted && !zero_run && (bus.data != exp_word);
        idx_inc    = {1'b0, idx} + 1'b1;
        done_store = accepted && (idx_inc == num_lat);
        at_limit   = (duration == DUR_LAST);
        err_next   = (mismatch && (error_num != '1)) ? error_num + 1'b1 : error_num;
    end

    // A store held across a stall is seen once: only a wen after a wen-low cycle is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed <= 1'b1;
        else      armed <= !bus.wen;
    end

    // NOTE: the expected RAM is left out of reset so a reset between runs keeps its contents.
    always_ff @(posedge clk) begin
        if (bus.exp_we) exp_ram[bus.exp_addr] <= bus.exp_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            error_num      <= '1;
            duration       <= '0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            idx            <= '0;
            num_lat        <= '0;
        end else begin
            case (state)
                S_CHECK: begin
                    if (duration != '1) duration <= duration + 1'b1;
                    if (accepted && !zero_run) begin
                        idx       <= idx + 1'b1;
                        error_num <= err_next;
                        if (mismatch && (error_num == '0)) begin
                            first_err_idx  <= idx;
                            first_err_data <= bus.data;
                        end
                    end
                    // A completing store beats a timeout landing on the same edge.
                    if (done_store || zero_run) begin
                        state <= S_REPORT;
                        pass  <= (err_next == '0);
                    end else if (at_limit) begin
                        state   <= S_REPORT;
                        timeout <= 1'b1;
                    end
                end
                default: begin
                    if (begin_hit) begin
                        state          <= S_CHECK;
                        error_num      <= '0;
                        duration       <= '0;
                        idx            <= '0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                        num_lat        <= (bus.check_num > DEPTH_LAT) ? DEPTH_LAT : bus.check_num;
                    end
                end
            endcase
        end
    end

    assign finish = (state == S_REPORT);
    assign busy   = (state == S_CHECK);

endmodule

// File: doc/store_stream_checker.md
Name: store_stream_checker

Overview:
- Parametrised self-checking monitor for CPU / cache-hierarchy simulations.
- Watches the core's data-memory store bus and arms on a begin-symbol store to a configurable test port.
- Compares each later test-port store against a run-time-loadable expected-value RAM, then reports error count, cycle duration, first-failure capture and timeout.
- Successor to the fixed-ROM checker: runtime check count, saturating counters, timeout, restart from report.

Parameters:
ADDR_W, 30, width of monitored word address
DATA_W, 32, width of monitored store data and expected entries
DEPTH, 256, expected-RAM entries (power of two)
IDX_W, 8, log2(DEPTH)
TEST_PORT, 30'hFF, word address of the result port
BEGIN_SYM, 32'h00000932, store value that starts a check run
ERR_W, 8, error counter width
DUR_W, 16, duration counter width
TIMEOUT, 16'hFFFF, max CHECK cycles before forced report

Ports:
clk  in  1  clock
rst  in  1  reset
addr  in  ADDR_W  monitored store word address
data  in  DATA_W  monitored store data
wen  in  1  monitored store enable (may stay high across stall cycles)
exp_we  in  1  expected-RAM write strobe
exp_addr  in  IDX_W  expected-RAM write index
exp_data  in  DATA_W  expected-RAM write data
check_num  in  IDX_W+1  entries to check; sampled on begin
error_num  out  ERR_W  mismatch count; all-ones = not started
duration  out  DUR_W  cycles spent in CHECK
finish  out  1  run complete
pass  out  1  finish with zero errors and no timeout
timeout  out  1  run ended by TIMEOUT
first_err_idx  out  IDX_W  index of first mismatch
first_err_data  out  DATA_W  store data of first mismatch
busy  out  1  in CHECK

Behaviour:
- Reset rst, asynchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: state IDLE, error_num all-ones, duration 0, finish 0, pass 0, timeout 0, first_err_idx 0, first_err_data 0, busy 0, idx 0, armed 1. Expected RAM is not reset.
- Stall dedup:
  - armed clears on any cycle with wen=1 and sets on any cycle with wen=0.
  - Accepted store = wen && armed && addr==TEST_PORT.
  - A store held high N cycles counts once.
- States: IDLE, CHECK, REPORT.
  - finish = (state==REPORT).
  - busy = (state==CHECK).
  - Both are decoded from the registered state, with no extra latency.
- IDLE:
  - Accepted store with data==BEGIN_SYM -> CHECK.
  - On that edge: error_num=0, duration=0, idx=0, timeout=0, first-error capture cleared, num_lat = min(check_num, DEPTH).
  - Any other store is ignored.
- CHECK:
  - duration increments every cycle, saturating at all-ones.
  - On an accepted store, data is compared with exp_ram[idx] (pre-write value if exp_we hits the same index that cycle).
  - On mismatch: error_num increments, saturating at all-ones.
  - On the first mismatch of the run: first_err_idx=idx, first_err_data=data.
  - idx increments on every accepted store.
  - If idx+1==num_lat on an accepted store -> REPORT at that edge; the error update lands on the same edge.
  - num_lat==0: -> REPORT on the cycle after begin; pass=1.
  - Timeout: if duration==TIMEOUT-1 with no completing store that cycle -> REPORT, timeout=1. A completing store in that same cycle wins (timeout=0).
  - BEGIN_SYM data seen in CHECK is compared like any other value; it does not restart.
- REPORT:
  - All counters hold.
  - pass = (error_num==0 && !timeout), registered on entry.
  - An accepted BEGIN_SYM store restarts: same actions as from IDLE, -> CHECK, pass cleared.
- Expected RAM:
  - exp_we writes exp_ram[exp_addr] in any state, 1-cycle write.
  - Reads are combinational on idx.
- Reset mid-run: immediate return to reset values; RAM contents kept.
- Non-test-port stores never affect idx, but they still clear armed.

Test Plan:
- Load RAM 0..3 = {0,1,1,2}, check_num=4; store BEGIN_SYM then 0,1,1,2 to TEST_PORT with 1-cycle wen pulses -> finish=1, error_num=0, pass=1, duration = cycles from begin to last store.
- Same run, but the 3rd store is 7 and the 4th is 9 -> error_num=2, first_err_idx=2, first_err_data=7, pass=0.
- A store held with wen=1 for 5 cycles (Dcache stall), addr=TEST_PORT -> counted once, idx advances by 1.
- TIMEOUT=20, check_num=4, only 2 stores after begin -> REPORT after 20 CHECK cycles, timeout=1, pass=0, error_num unchanged.
- 300 mismatching stores with check_num=256 and DEPTH=256 -> check_num clamped to 256, error_num saturates at 255; stores to addr 0x100 with wen never counted.
- In REPORT, store BEGIN_SYM -> busy=1, error_num=0, rerun passes. Assert rst low mid-CHECK -> error_num=255, finish=0, RAM retained for the following run.
